axi_slave_mux_rd: RTL and testbench
===================================

AXI_SLAVE_MUX_RD -- requirements
Module: axi_slave_mux_rd

Interface
REQ-001 Parameter DATA_WIDTH, default 1024, R data width.
REQ-002 Parameter ADDR_WIDTH, default 64, AR address width.
REQ-003 Parameter ID_WIDTH, default 8, RID width.
REQ-004 Parameter USER_WIDTH, default 8, RUSER width.
REQ-005 Parameter SEL_BIT, default 31, address bit selecting the slave: 0 selects s0, 1 selects s1.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset, with the ports listed in REQ-007 and REQ-008.
REQ-007 ACLK  input  1  sole clock; all state updates on its rising edge.
REQ-008 ARESET  input  1  synchronous, active-high reset.
REQ-009 m_ARADDR  input  ADDR_WIDTH  master read address.
REQ-010 m_ARLEN  input  8  master burst length (beats minus 1).
REQ-011 m_ARVALID  input  1  master AR valid.
REQ-012 m_ARREADY  output  1  AR ready to master.
REQ-013 m_RID / m_RDATA / m_RRESP / m_RUSER  output  ID_WIDTH / DATA_WIDTH / 2 / USER_WIDTH  routed R payload.
REQ-014 m_RLAST  output  1  routed last beat.
REQ-015 m_RVALID  output  1  routed R valid.
REQ-016 m_RREADY  input  1  master R ready.
REQ-017 sN_ARVALID, N in {0,1}  output  1  AR valid to slave N.
REQ-018 sN_ARREADY  input  1  AR ready from slave N.
REQ-019 sN_RID / sN_RDATA / sN_RRESP / sN_RUSER  input  ID_WIDTH / DATA_WIDTH / 2 / USER_WIDTH  R payload from slave N.
REQ-020 sN_RLAST  input  1  last beat from slave N.
REQ-021 sN_RVALID  input  1  R valid from slave N.
REQ-022 sN_RREADY  output  1  R ready to slave N.
REQ-023 busy  output  1  high whenever the state is not IDLE.
REQ-024 len_err  output  1  sticky burst-length mismatch flag.

Function
REQ-025 The FSM SHALL have the states IDLE, ADDR and DATA; exactly one transaction is in flight at a time.
REQ-026 IDLE SHALL drive m_ARREADY=0, all sN_ARVALID=0, all sN_RREADY=0, m_RVALID=0, m_RLAST=0 and the m_R payload to 0.
REQ-027 In IDLE with m_ARVALID=1, the block SHALL register sel=m_ARADDR[SEL_BIT] and len=m_ARLEN, then go to ADDR the next cycle; minimum AR latency is 1 cycle.
REQ-028 In ADDR, s[sel]_ARVALID SHALL equal m_ARVALID, the other slave's ARVALID SHALL be 0, and m_ARREADY SHALL equal s[sel]_ARREADY, all combinationally.
REQ-029 On the ADDR handshake (m_ARVALID & s[sel]_ARREADY), the block SHALL clear the 8-bit beat counter to 0 and go to DATA.
REQ-030 If m_ARVALID deasserts in ADDR, the block SHALL remain in ADDR with sel unchanged.
REQ-031 In DATA, the m_R outputs SHALL equal the s[sel]_R inputs combinationally, s[sel]_RREADY SHALL equal m_RREADY, and the other slave's RREADY SHALL be 0.
REQ-032 In DATA, RVALID and the payload of the unselected slave SHALL be ignored.
REQ-033 Each R handshake (m_RVALID & m_RREADY) in DATA SHALL increment the beat counter; the counter SHALL saturate at 255.
REQ-034 A handshake with m_RLAST=1 SHALL return the FSM to IDLE the next cycle.
REQ-035 A new AR is accepted no earlier than the cycle after IDLE is re-entered, giving one bubble cycle between bursts.
REQ-036 len_err SHALL set on an R handshake where (RLAST=1 and count!=len) or (RLAST=0 and count==len).
REQ-037 Once set, len_err SHALL stay 1 until reset; routing is unaffected by the error.
REQ-038 m_ARREADY SHALL be 0 in IDLE and DATA, so no AR is accepted while a burst is open.

Reset
REQ-039 When ARESET=1 at a clock edge, the block SHALL set state=IDLE, sel=0, len=0, counter=0, busy=0 and len_err=0.
REQ-040 After reset, all outputs SHALL hold the IDLE values of REQ-026.
REQ-041 Reset asserted mid-burst SHALL abort the burst, leaving no sN_ARVALID or sN_RREADY asserted in the following cycle.

Verification
REQ-042 ARADDR[31]=0, ARLEN=3, s0_ARREADY=1 -> s0_ARVALID=1 in cycle 1, s1_ARVALID=0; 4 s0 beats are forwarded; IDLE after the RLAST handshake; len_err=0.
REQ-043 ARADDR[31]=1, ARLEN=0, s1_ARREADY held 0 for 3 cycles -> m_ARREADY=0 and state ADDR for 3 cycles; handshake on cycle 4; single beat routed from s1.
REQ-044 In DATA with sel=0, s1_RVALID=1 with RDATA=0xA5 -> m_RVALID follows s0 only and s1_RREADY=0.
REQ-045 ARLEN=3, slave asserts RLAST on beat 1 -> len_err=1 from the next cycle; FSM returns to IDLE; len_err persists through a following correct burst.
REQ-046 ARESET=1 during beat 2 of a 4-beat burst -> next cycle busy=0 and all sN_RREADY=0; a new AR to s1 completes normally.
REQ-047 m_RREADY=0 for 2 cycles mid-burst -> the beat counter holds, s[sel]_RREADY=0, and the payload passes through unchanged.

Source files
------------

// File: rtl/axi_slave_mux_rd.sv
// AXI read-channel demultiplexer: one master routed to one of two slaves by
// a single address bit, with one transaction in flight at a time and a
// sticky flag for bursts whose RLAST does not match the requested length.
module axi_slave_mux_rd #(
   parameter int DATA_WIDTH = 1024,
   parameter int ADDR_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int USER_WIDTH = 8,
   parameter int SEL_BIT    = 31
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   // master side
   input  logic [ADDR_WIDTH-1:0] m_ARADDR,
   input  logic [7:0]            m_ARLEN,
   input  logic                  m_ARVALID,
   output logic                  m_ARREADY,
   output logic [ID_WIDTH-1:0]   m_RID,
   output logic [DATA_WIDTH-1:0] m_RDATA,
   output logic [1:0]            m_RRESP,
   output logic [USER_WIDTH-1:0] m_RUSER,
   output logic                  m_RLAST,
   output logic                  m_RVALID,
   input  logic                  m_RREADY,
   // slave 0
   output logic                  s0_ARVALID,
   input  logic                  s0_ARREADY,
   input  logic [ID_WIDTH-1:0]   s0_RID,
   input  logic [DATA_WIDTH-1:0] s0_RDATA,
   input  logic [1:0]            s0_RRESP,
   input  logic [USER_WIDTH-1:0] s0_RUSER,
   input  logic                  s0_RLAST,
   input  logic                  s0_RVALID,
   output logic                  s0_RREADY,
   // slave 1
   output logic                  s1_ARVALID,
   input  logic                  s1_ARREADY,
   input  logic [ID_WIDTH-1:0]   s1_RID,
   input  logic [DATA_WIDTH-1:0] s1_RDATA,
   input  logic [1:0]            s1_RRESP,
   input  logic [USER_WIDTH-1:0] s1_RUSER,
   input  logic                  s1_RLAST,
   input  logic                  s1_RVALID,
   output logic                  s1_RREADY,
   // status
   output logic                  busy,
   output logic                  len_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t     state_q, state_d;
   logic       sel_q, sel_d;
   logic [7:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
   logic       len_err_q, len_err_d;

   logic       ar_ready_sel;
   logic       r_valid_sel;
   logic       r_last_sel;

   // Selected slave's AR ready and R valid/last, used by the handshake logic
   always_comb begin
      ar_ready_sel = sel_q ? s1_ARREADY : s0_ARREADY;
      r_valid_sel  = sel_q ? s1_RVALID  : s0_RVALID;
      r_last_sel   = sel_q ? s1_RLAST   : s0_RLAST;
   end

   // Next-state logic and all routed outputs; everything idles at zero
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      len_err_d  = len_err_q;
      m_ARREADY  = 1'b0;
      s0_ARVALID = 1'b0;
      s1_ARVALID = 1'b0;
      s0_RREADY  = 1'b0;
      s1_RREADY  = 1'b0;
      m_RVALID   = 1'b0;
      m_RLAST    = 1'b0;
      m_RID      = '0;
      m_RDATA    = '0;
      m_RRESP    = '0;
      m_RUSER    = '0;
      case (state_q)
         IDLE: begin
            if (m_ARVALID) begin
               sel_d   = m_ARADDR[SEL_BIT];
               len_d   = m_ARLEN;
               state_d = ADDR;
            end
         end
         ADDR: begin
            s0_ARVALID = ~sel_q & m_ARVALID;
            s1_ARVALID =  sel_q & m_ARVALID;
            m_ARREADY  = ar_ready_sel;
            if (m_ARVALID && ar_ready_sel) begin
               cnt_d   = 8'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            m_RVALID  = r_valid_sel;
            m_RLAST   = r_last_sel;
            m_RID     = sel_q ? s1_RID   : s0_RID;
            m_RDATA   = sel_q ? s1_RDATA : s0_RDATA;
            m_RRESP   = sel_q ? s1_RRESP : s0_RRESP;
            m_RUSER   = sel_q ? s1_RUSER : s0_RUSER;
            s0_RREADY = ~sel_q & m_RREADY;
            s1_RREADY =  sel_q & m_RREADY;
            if (r_valid_sel && m_RREADY) begin
               if (cnt_q != 8'hFF) begin
                  cnt_d = cnt_q + 8'd1;
               end
               if ((r_last_sel && cnt_q != len_q) || (!r_last_sel && cnt_q == len_q)) begin
                  len_err_d = 1'b1;
               end
               if (r_last_sel) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         len_q     <= 8'd0;
         cnt_q     <= 8'd0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_slave_mux_rd.sv
// Directed and randomized bursts through axi_slave_mux_rd, checked against a
// transaction-level expectation of routing and burst-length error tracking.
module tb_axi_slave_mux_rd;

   localparam int DW = 64;
   localparam int AW = 64;
   localparam int IW = 8;
   localparam int UW = 8;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [AW-1:0] m_ARADDR;
   logic [7:0]    m_ARLEN;
   logic          m_ARVALID;
   logic          m_ARREADY;
   logic [IW-1:0] m_RID;
   logic [DW-1:0] m_RDATA;
   logic [1:0]    m_RRESP;
   logic [UW-1:0] m_RUSER;
   logic          m_RLAST;
   logic          m_RVALID;
   logic          m_RREADY;
   logic          busy;
   logic          len_err;

   // slave-side stimulus and observed outputs, indexed by slave number
   logic          sv_arready [2];
   logic [IW-1:0] sv_rid     [2];
   logic [DW-1:0] sv_rdata   [2];
   logic [1:0]    sv_rresp   [2];
   logic [UW-1:0] sv_ruser   [2];
   logic          sv_rlast   [2];
   logic          sv_rvalid  [2];
   logic          arvalid_o  [2];
   logic          rready_o   [2];

   int  tests = 0;
   int  fails = 0;
   bit  exp_err = 1'b0;

   always #5 ACLK = ~ACLK;

   axi_slave_mux_rd #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW), .SEL_BIT(31)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
      .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RUSER(m_RUSER),
      .m_RLAST(m_RLAST), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
      .s0_ARVALID(arvalid_o[0]), .s0_ARREADY(sv_arready[0]),
      .s0_RID(sv_rid[0]), .s0_RDATA(sv_rdata[0]), .s0_RRESP(sv_rresp[0]), .s0_RUSER(sv_ruser[0]),
      .s0_RLAST(sv_rlast[0]), .s0_RVALID(sv_rvalid[0]), .s0_RREADY(rready_o[0]),
      .s1_ARVALID(arvalid_o[1]), .s1_ARREADY(sv_arready[1]),
      .s1_RID(sv_rid[1]), .s1_RDATA(sv_rdata[1]), .s1_RRESP(sv_rresp[1]), .s1_RUSER(sv_ruser[1]),
      .s1_RLAST(sv_rlast[1]), .s1_RVALID(sv_rvalid[1]), .s1_RREADY(rready_o[1]),
      .busy(busy), .len_err(len_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // fresh random payload on both slaves
   task automatic applyStimulus();
      for (int i = 0; i < 2; i++) begin
         sv_rid[i]    = IW'($urandom);
         sv_rdata[i]  = {$urandom, $urandom};
         sv_rresp[i]  = 2'($urandom);
         sv_ruser[i]  = UW'($urandom);
         sv_rlast[i]  = 1'($urandom);
         sv_rvalid[i] = 1'($urandom);
      end
   endtask

   // everything quiet, payload forced to zero
   task automatic checkIdle(input string tag);
      check({tag, ".busy"},     64'(busy), 64'd0);
      check({tag, ".arready"},  64'(m_ARREADY), 64'd0);
      check({tag, ".arvalid0"}, 64'(arvalid_o[0]), 64'd0);
      check({tag, ".arvalid1"}, 64'(arvalid_o[1]), 64'd0);
      check({tag, ".rready0"},  64'(rready_o[0]), 64'd0);
      check({tag, ".rready1"},  64'(rready_o[1]), 64'd0);
      check({tag, ".rvalid"},   64'(m_RVALID), 64'd0);
      check({tag, ".rlast"},    64'(m_RLAST), 64'd0);
      check({tag, ".rid"},      64'(m_RID), 64'd0);
      check({tag, ".rdata"},    64'(m_RDATA), 64'd0);
      check({tag, ".rresp"},    64'(m_RRESP), 64'd0);
      check({tag, ".ruser"},    64'(m_RUSER), 64'd0);
      check({tag, ".len_err"},  64'(len_err), 64'(exp_err));
   endtask

   // data-phase routing from slave s
   task automatic checkOutput(input string tag, input int s);
      check({tag, ".busy"},      64'(busy), 64'd1);
      check({tag, ".arready"},   64'(m_ARREADY), 64'd0);
      check({tag, ".arvalid0"},  64'(arvalid_o[0]), 64'd0);
      check({tag, ".arvalid1"},  64'(arvalid_o[1]), 64'd0);
      check({tag, ".rvalid"},    64'(m_RVALID), 64'(sv_rvalid[s]));
      check({tag, ".rlast"},     64'(m_RLAST), 64'(sv_rlast[s]));
      check({tag, ".rid"},       64'(m_RID), 64'(sv_rid[s]));
      check({tag, ".rdata"},     64'(m_RDATA), 64'(sv_rdata[s]));
      check({tag, ".rresp"},     64'(m_RRESP), 64'(sv_rresp[s]));
      check({tag, ".ruser"},     64'(m_RUSER), 64'(sv_ruser[s]));
      check({tag, ".rready_sel"}, 64'(rready_o[s]), 64'(m_RREADY));
      check({tag, ".rready_oth"}, 64'(rready_o[1-s]), 64'd0);
      check({tag, ".len_err"},   64'(len_err), 64'(exp_err));
   endtask

   // One transaction: AR to slave s with ARLEN=len, ar_wait refused cycles,
   // slave raises RLAST on beat last_at, optional 2-cycle stall before beat
   // stall_beat, optional reset during the handshake of beat reset_beat.
   task automatic run_burst(input int s, input int len, input int ar_wait,
                            input int last_at, input int stall_beat, input int reset_beat);
      int  b;
      int  cyc;
      int  stall_cnt;
      int  cnt;
      bit  hs;
      bit  done;
      bit  rst_now;
      // IDLE cycle: request captured, nothing forwarded yet
      applyStimulus();
      m_ARADDR      = {$urandom, $urandom};
      m_ARADDR[31]  = 1'(s);
      m_ARLEN       = 8'(len);
      m_ARVALID     = 1'b1;
      sv_arready[0] = 1'($urandom);
      sv_arready[1] = 1'($urandom);
      m_RREADY      = 1'b1;
      @(negedge ACLK);
      checkIdle("ar_idle");
      tick();
      // ADDR cycles where the slave refuses; address changes must not reroute
      for (int w = 0; w < ar_wait; w++) begin
         applyStimulus();
         m_ARVALID       = 1'($urandom);
         m_ARADDR        = {$urandom, $urandom};
         sv_arready[s]   = 1'b0;
         sv_arready[1-s] = 1'($urandom);
         @(negedge ACLK);
         check("addr_wait.busy",        64'(busy), 64'd1);
         check("addr_wait.arvalid_sel", 64'(arvalid_o[s]), 64'(m_ARVALID));
         check("addr_wait.arvalid_oth", 64'(arvalid_o[1-s]), 64'd0);
         check("addr_wait.arready",     64'(m_ARREADY), 64'd0);
         check("addr_wait.rvalid",      64'(m_RVALID), 64'd0);
         check("addr_wait.rready_sel",  64'(rready_o[s]), 64'd0);
         tick();
      end
      // ADDR handshake
      m_ARVALID       = 1'b1;
      sv_arready[s]   = 1'b1;
      sv_arready[1-s] = 1'b0;
      @(negedge ACLK);
      check("addr_hs.arready",     64'(m_ARREADY), 64'd1);
      check("addr_hs.arvalid_sel", 64'(arvalid_o[s]), 64'd1);
      check("addr_hs.arvalid_oth", 64'(arvalid_o[1-s]), 64'd0);
      tick();
      m_ARVALID     = 1'b0;
      sv_arready[0] = 1'b0;
      sv_arready[1] = 1'b0;
      // DATA phase
      b = 0; cyc = 0; stall_cnt = 0; done = 1'b0; rst_now = 1'b0;
      while (!done && cyc < 2000) begin
         applyStimulus();
         sv_rvalid[s]   = ($urandom % 4) != 0;
         sv_rlast[s]    = (b == last_at);
         sv_rvalid[1-s] = 1'b1;
         sv_rdata[1-s]  = 64'hA5;
         if (b == stall_beat && stall_cnt < 2) begin
            m_RREADY = 1'b0;
            stall_cnt++;
         end else begin
            m_RREADY = ($urandom % 8) != 0;
         end
         if (b == reset_beat) begin
            sv_rvalid[s] = 1'b1;
            m_RREADY     = 1'b1;
            ARESET       = 1'b1;
            rst_now      = 1'b1;
         end
         @(negedge ACLK);
         checkOutput("data", s);
         hs = sv_rvalid[s] && m_RREADY;
         if (hs) begin
            cnt = (b > 255) ? 255 : b;
            if ((sv_rlast[s] && cnt != len) || (!sv_rlast[s] && cnt == len))
               exp_err = 1'b1;
            if (sv_rlast[s]) done = 1'b1;
            b++;
         end
         tick();
         cyc++;
         if (rst_now) begin
            ARESET  = 1'b0;
            exp_err = 1'b0;
            applyStimulus();
            @(negedge ACLK);
            checkIdle("after_reset");
            tick();
            return;
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $error("[TB] FAIL burst_timeout observed=%0d beats expected=%0d", b, last_at + 1);
      end
      // Bubble cycle back in IDLE, error flag now reflects this burst
      applyStimulus();
      m_ARVALID = 1'b0;
      @(negedge ACLK);
      checkIdle("post_burst");
      tick();
   endtask

   initial begin
      ARESET    = 1'b1;
      m_ARADDR  = '0;
      m_ARLEN   = '0;
      m_ARVALID = 1'b0;
      m_RREADY  = 1'b0;
      for (int i = 0; i < 2; i++) sv_arready[i] = 1'b0;
      applyStimulus();
      tick();
      tick();
      @(negedge ACLK);
      checkIdle("in_reset");
      ARESET = 1'b0;
      tick();
      applyStimulus();
      @(negedge ACLK);
      checkIdle("after_init");
      tick();

      // 4-beat burst to s0, immediate AR accept
      run_burst(0, 3, 0, 3, -1, -1);
      // single beat to s1, slave refuses AR for 3 cycles
      run_burst(1, 0, 3, 0, -1, -1);
      // master stalls R for 2 cycles mid-burst
      run_burst(0, 3, 0, 3, 1, -1);
      // full-length 256-beat burst exercises every counter value
      run_burst(1, 255, 1, 255, 100, -1);
      // randomized well-formed bursts
      for (int k = 0; k < 8; k++) begin
         int len;
         len = $urandom_range(0, 7);
         run_burst(int'($urandom % 2), len, $urandom_range(0, 2), len,
                   $urandom_range(0, len), -1);
      end
      check("no_err_yet", 64'(len_err), 64'd0);
      // RLAST too early on beat 1 of a 4-beat burst
      run_burst(0, 3, 0, 1, -1, -1);
      check("err_set", 64'(len_err), 64'd1);
      // correct burst afterwards, flag stays sticky
      run_burst(1, 2, 1, 2, -1, -1);
      check("err_sticky", 64'(len_err), 64'd1);
      // reset during beat 2 of a 4-beat burst, then a clean burst to s1
      run_burst(0, 3, 0, 3, -1, 2);
      run_burst(1, 3, 0, 3, -1, -1);
      check("clean_after_reset", 64'(len_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
